// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath.
//   MAT_N/ELEM_W/MAT_W : matrix geometry (4x4 of 16-bit, 256-bit packed)
//   state_e            : store sequencer states
//   elem_off(row,col)  : bit offset of element [row][col] in a packed matrix
package matrix_pkg;
  localparam int MAT_N  = 4;
  localparam int ELEM_W = 16;
  localparam int MAT_W  = 256;
  localparam int K_W    = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_e;

  // row*64 + col*16, built by concatenation so the width is exact.
  function automatic logic [7:0] elem_off(input logic [1:0] row, input logic [1:0] col);
    return {row, col, 4'b0000};
  endfunction
endpackage

// File: rtl/matrix_elem_sel.sv
// Combinational select of one 16-bit element from a packed 4x4 matrix.
//   mat_i       : packed matrix
//   k_i         : beat index 0..15
//   transpose_i : 0 = row-major (k = row*4+col), 1 = column-major
//   elem_o      : selected element
module matrix_elem_sel
  import matrix_pkg::*;
(
  input  logic [MAT_W-1:0]  mat_i,
  input  logic [K_W-1:0]    k_i,
  input  logic              transpose_i,
  output logic [ELEM_W-1:0] elem_o
);
  logic [1:0] row, col;
  logic [7:0] off;

  // Column-major just swaps which half of k names the row.
  assign row    = transpose_i ? k_i[1:0] : k_i[3:2];
  assign col    = transpose_i ? k_i[3:2] : k_i[1:0];
  assign off    = elem_off(row, col);
  assign elem_o = mat_i[off +: ELEM_W];
endmodule

// File: rtl/matrix_store.sv
// Writes one packed 4x4 result matrix to memory as 16 sequential words.
// Ports:
//   clk, reset          : clock, async active-high reset
//   start               : one-cycle request, honoured only in IDLE
//   m_in, base_addr     : matrix and start address, captured with start
//   transpose           : column-major order (only with MATRIX_STORE_TRANSPOSE_EN)
//   mem_addr/wdata/we   : registered write port; beat taken on mem_we && mem_ready
//   mem_ready           : memory accept
//   busy, done          : busy in WRITE/DONE, done a one-cycle pulse in DONE
// Optional macro: MATRIX_STORE_TRANSPOSE_EN adds the transpose input.
module matrix_store
  import matrix_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MAT_W-1:0]  m_in,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef MATRIX_STORE_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ELEM_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);
  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d, k_nxt;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic               tr_q, tr_d, tr_in;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ELEM_W-1:0]  wdata_q, wdata_d, sel_elem;
  logic               we_q, we_d;

`ifdef MATRIX_STORE_TRANSPOSE_EN
  assign tr_in = transpose;
`else
  assign tr_in = 1'b0;
`endif

  assign k_nxt = k_q + 4'd1;

  // Looks one beat ahead so the next element is ready to register on accept.
  matrix_elem_sel u_sel (
    .mat_i       (mat_q),
    .k_i         (k_nxt),
    .transpose_i (tr_q),
    .elem_o      (sel_elem)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mat_d   = mat_q;
    tr_d    = tr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: if (start) begin
        mat_d   = m_in;
        tr_d    = tr_in;
        k_d     = '0;
        addr_d  = base_addr;
        // Element 0 sits at bit 0 in either order, so take it straight from m_in.
        wdata_d = m_in[ELEM_W-1:0];
        we_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (we_q && mem_ready) begin
        if (k_q == 4'd15) begin
          we_d    = 1'b0;
          state_d = DONE;
        end else begin
          k_d     = k_nxt;
          // Running sum equals base + k*stride modulo 2^ADDR_W.
          addr_d  = addr_q + ADDR_W'(ADDR_STRIDE);
          wdata_d = sel_elem;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      mat_q   <= '0;
      tr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mat_q   <= mat_d;
      tr_q    <= tr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_matrix_store.sv
module tb_matrix_store;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, start2 = 1'b0;
  logic [255:0] m_in = '0;
  logic [15:0]  base_addr = '0;
  logic         mem_ready = 1'b1;
  logic [15:0]  mem_addr, mem_wdata, mem_addr2, mem_wdata2;
  logic         mem_we, busy, done, mem_we2, busy2, done2;
`ifdef MATRIX_STORE_TRANSPOSE_EN
  logic         transpose = 1'b0;
`endif

  matrix_store #(.ADDR_W(16), .ADDR_STRIDE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .m_in(m_in), .base_addr(base_addr),
`ifdef MATRIX_STORE_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .done(done));

  matrix_store #(.ADDR_W(16), .ADDR_STRIDE(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .m_in(m_in), .base_addr(base_addr),
`ifdef MATRIX_STORE_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
    .mem_ready(mem_ready), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [15:0] d; } exp_t;
  exp_t q[$];
  exp_t q2[$];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  int busy_cnt = 0, done_cnt = 0, done_rel = -1, first_rel = -1, beats = 0;
  int beats2 = 0, done2_cnt = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", n, got, exp, cyc - t0);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the stride-1 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_rel = cyc - t0; end
      if (mem_we) begin
        if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          if (beats == 0 && first_rel < 0) first_rel = cyc - t0;
          chk("addr", {16'h0, mem_addr}, {16'h0, q[0].a});
          chk("data", {16'h0, mem_wdata}, {16'h0, q[0].d});
          if (mem_ready) begin void'(q.pop_front()); beats++; end
        end
      end
    end
  end

  // Scoreboard monitor for the stride-2 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (done2) done2_cnt++;
      if (mem_we2) begin
        if (q2.size() == 0) chk("unexpected_write2", 32'd1, 32'd0);
        else begin
          chk("addr2", {16'h0, mem_addr2}, {16'h0, q2[0].a});
          chk("data2", {16'h0, mem_wdata2}, {16'h0, q2[0].d});
          if (mem_ready) begin void'(q2.pop_front()); beats2++; end
        end
      end
    end
  end

  function automatic logic [255:0] mk_mat(input logic [15:0] b);
    logic [255:0] m;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = b + 16'(k);
    return m;
  endfunction

  // Expected beats, hand formula: row-major value b+k, column-major b+(k%4)*4+k/4.
  task automatic push_exp(input logic [15:0] base, input logic [15:0] b, input bit tr);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.a = base + 16'(k);
      e.d = tr ? b + 16'((k % 4) * 4 + k / 4) : b + 16'(k);
      q.push_back(e);
    end
  endtask

  task automatic issue_start(input logic [15:0] base, input logic [255:0] m);
    @(posedge clk); #1;
    busy_cnt = 0; done_cnt = 0; done_rel = -1; first_rel = -1; beats = 0;
    start = 1'b1; base_addr = base; m_in = m; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string n, input int exp_rel, input int exp_busy);
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    if (i == 300) chk({n, "_timeout"}, 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({n, "_done_cycle"}, done_rel, exp_rel);
    chk({n, "_done_pulses"}, done_cnt, 1);
    chk({n, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({n, "_beats"}, beats, 16);
    chk({n, "_first_write"}, first_rel, 1);
    chk({n, "_left"}, q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Basic store.
    push_exp(16'h0100, 16'h1000, 1'b0);
    issue_start(16'h0100, mk_mat(16'h1000));
    wait_done("basic", 17, 17);

    // Backpressure: hold ready low for 3 cycles while beat 5 is presented.
    push_exp(16'h0100, 16'h1000, 1'b0);
    issue_start(16'h0100, mk_mat(16'h1000));
    for (int i = 0; i < 50; i++) begin
      if (beats == 5) break;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b1;
    wait_done("bp", 20, 20);

    // Start while busy is ignored; later input changes do not leak in.
    push_exp(16'h0100, 16'h1000, 1'b0);
    issue_start(16'h0100, mk_mat(16'h1000));
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; m_in = {16{16'hFFFF}}; base_addr = 16'h0200;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 17, 17);

    // Wrap with stride 2 on the second instance.
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.a = 16'hFFFC + 16'(2 * k);
      e.d = 16'h2000 + 16'(k);
      q2.push_back(e);
    end
    @(posedge clk); #1;
    beats2 = 0; done2_cnt = 0;
    start2 = 1'b1; base_addr = 16'hFFFC; m_in = mk_mat(16'h2000);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done2_cnt > 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_done", done2_cnt, 1);
    chk("wrap_beats", beats2, 16);
    chk("wrap_left", q2.size(), 0);
    chk("wrap_last_addr", mem_addr2, 16'h001A);

    // Reset after the 7th accepted write.
    push_exp(16'h0100, 16'h1000, 1'b0);
    issue_start(16'h0100, mk_mat(16'h1000));
    for (int i = 0; i < 50; i++) begin
      if (beats == 7) break;
      @(posedge clk); #1;
    end
    chk("mid_beats", beats, 7);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt, 0);
    push_exp(16'h0300, 16'h3000, 1'b0);
    issue_start(16'h0300, mk_mat(16'h3000));
    wait_done("restart", 17, 17);

`ifdef MATRIX_STORE_TRANSPOSE_EN
    transpose = 1'b1;
    push_exp(16'h0100, 16'h1000, 1'b1);
    issue_start(16'h0100, mk_mat(16'h1000));
    wait_done("tr1", 17, 17);
    transpose = 1'b0;
    push_exp(16'h0100, 16'h1000, 1'b0);
    issue_start(16'h0100, mk_mat(16'h1000));
    wait_done("tr0", 17, 17);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
